// File: rtl/booth_fixed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_fixed_multiplier
// Description : Sequential signed fixed-point multiplier, radix-4 Booth, one
//               digit per clock. Define MULT_SATURATE_EN to saturate on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_fixed_multiplier #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             finish
);

    localparam int c_ITERS = WIDTH / 2;
    localparam int c_CNT_W = (c_ITERS > 1) ? $clog2(c_ITERS) : 1;
    localparam int c_PW    = 2 * WIDTH;
    localparam int c_HI_W  = c_PW - (FRAC_BITS + WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_PW-1:0]    ash_q, ash_d;
    logic [WIDTH:0]     bext_q, bext_d;
    logic [c_PW-1:0]    acc_q, acc_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               finish_q, finish_d;

    logic [c_PW-1:0]    w_pp;
    logic [c_PW-1:0]    w_prod;
    logic [c_HI_W-1:0]  w_upper;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_res;

    // bext_q holds B with an implicit 0 below the LSB; the low 3 bits are the current triplet
    always_comb begin
        w_pp = '0;
        case (bext_q[2:0])
            3'b001, 3'b010: w_pp = ash_q;
            3'b011:         w_pp = ash_q << 1;
            3'b100:         w_pp = -(ash_q << 1);
            3'b101, 3'b110: w_pp = -ash_q;
            default:        w_pp = '0;
        endcase
    end

    assign w_prod  = acc_q + w_pp;
    assign w_upper = w_prod[c_PW-1 -: c_HI_W];
    assign w_ovf   = !((&w_upper) || (~|w_upper));

`ifdef MULT_SATURATE_EN
    always_comb begin
        w_res = w_prod[FRAC_BITS+WIDTH-1:FRAC_BITS];
        if (w_ovf) begin
            w_res = w_prod[c_PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_prod[FRAC_BITS+WIDTH-1:FRAC_BITS];
`endif

    always_comb begin
        state_d  = state_q;
        ash_d    = ash_q;
        bext_d   = bext_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        finish_d = finish_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ash_d    = {{WIDTH{A[WIDTH-1]}}, A};
                    bext_d   = {B, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    finish_d = 1'b0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d  = w_prod;
                ash_d  = ash_q << 2;
                bext_d = bext_q >> 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == c_CNT_W'(c_ITERS - 1)) begin
                    result_d = w_res;
                    ovf_d    = w_ovf;
                    finish_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ash_q    <= '0;
            bext_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ash_q    <= ash_d;
            bext_q   <= bext_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            finish_q <= finish_d;
        end
    end

    assign result        = result_q;
    assign overflow_flag = ovf_q;
    assign finish        = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_fixed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_fixed_multiplier
// Description : Directed and random self-checking bench for booth_fixed_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_fixed_multiplier;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        start;
    logic [15:0] result;
    logic        ovf;
    logic        finish;

    int n_checks;
    int n_fail;

    booth_fixed_multiplier #(
        .WIDTH     (16),
        .FRAC_BITS (10)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .A             (a_in),
        .B             (b_in),
        .start         (start),
        .result        (result),
        .overflow_flag (ovf),
        .finish        (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat = rising edges from the accepting edge to finish, -1 on timeout
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int hold, output int lat);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            if (finish) begin
                lat = k - 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a_in  = 16'h0;
        b_in  = 16'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (result !== 16'h0000 || ovf !== 1'b0 || finish !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: result=%h ovf=%b finish=%b, need 0000/0/0", result, ovf, finish);
        end
    endtask

    task automatic test_unity();
        int lat;
        run_op(16'h0400, 16'h0400, 4, lat);
        n_checks++;
        if (lat < 0 || lat > 9) begin
            n_fail++;
            $display("FAIL unity_latency: got %0d edges, need 0..9", lat);
        end
        n_checks++;
        if (result !== 16'h0400 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL unity: result=%h ovf=%b, need 0400/0", result, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (result !== 16'h0400 || ovf !== 1'b0 || finish !== 1'b1) begin
                n_fail++;
                $display("FAIL unity_hold cycle %0d: result=%h ovf=%b finish=%b, need 0400/0/1",
                         i, result, ovf, finish);
            end
        end
    endtask

    task automatic test_mixed_sign();
        int lat;
        run_op(16'h0800, 16'hF400, 1, lat);
        n_checks++;
        if (lat < 0 || result !== 16'hE800 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_ab: lat=%0d result=%h ovf=%b, need E800/0", lat, result, ovf);
        end
        run_op(16'hF400, 16'h0800, 1, lat);
        n_checks++;
        if (lat < 0 || result !== 16'hE800 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_ba: lat=%0d result=%h ovf=%b, need E800/0", lat, result, ovf);
        end
        run_op(16'h1234, 16'h0000, 1, lat);
        n_checks++;
        if (lat < 0 || result !== 16'h0000 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL zero: lat=%0d result=%h ovf=%b, need 0000/0", lat, result, ovf);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] exp_r;
`ifdef MULT_SATURATE_EN
        exp_r = 16'h7FFF;
`else
        exp_r = 16'h0000;
`endif
        run_op(16'h4000, 16'h4000, 1, lat);
        n_checks++;
        if (lat < 0 || result !== exp_r || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_pos: lat=%0d result=%h ovf=%b, need %h/1", lat, result, ovf, exp_r);
        end
    endtask

    task automatic test_most_negative();
        int lat;
        logic [15:0] exp_r;
        logic [15:0] exp_mm;
`ifdef MULT_SATURATE_EN
        exp_r  = 16'h7FFF;
        exp_mm = 16'h7FFF;
`else
        exp_r  = 16'h8000;
        exp_mm = 16'h0000;
`endif
        run_op(16'h8000, 16'hFC00, 1, lat);
        n_checks++;
        if (lat < 0 || result !== exp_r || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_times_neg1: lat=%0d result=%h ovf=%b, need %h/1", lat, result, ovf, exp_r);
        end
        run_op(16'h8000, 16'h8000, 1, lat);
        n_checks++;
        if (lat < 0 || result !== exp_mm || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL min_times_min: lat=%0d result=%h ovf=%b, need %h/1", lat, result, ovf, exp_mm);
        end
        run_op(16'h8000, 16'h0400, 1, lat);
        n_checks++;
        if (lat < 0 || result !== 16'h8000 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL min_times_one: lat=%0d result=%h ovf=%b, need 8000/0", lat, result, ovf);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_in  = 16'h0C00;
        b_in  = 16'h0A00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 16'h7777;
        b_in  = 16'h5555;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (result !== 16'h0000 || ovf !== 1'b0 || finish !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: result=%h ovf=%b finish=%b, need 0000/0/0", result, ovf, finish);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (finish !== 1'b0 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_after: result=%h finish=%b, need 0000/0", result, finish);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] a;
        logic [15:0] b;
        logic signed [31:0] p;
        logic [15:0] exp_r;
        logic [6:0]  hi;
        logic        exp_o;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 4 == 1) a = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
            p     = 32'($signed(a)) * 32'($signed(b));
            hi    = p[31:25];
            exp_o = !((&hi) || (~|hi));
            exp_r = p[25:10];
`ifdef MULT_SATURATE_EN
            if (exp_o) exp_r = p[31] ? 16'h8000 : 16'h7FFF;
`endif
            run_op(a, b, 1, lat);
            n_checks++;
            if (lat < 0 || lat > 9 || result !== exp_r || ovf !== exp_o) begin
                n_fail++;
                $display("FAIL random %0d a=%h b=%h: lat=%0d result=%h ovf=%b, need %h/%b",
                         i, a, b, lat, result, ovf, exp_r, exp_o);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unity();
        test_mixed_sign();
        test_overflow();
        test_most_negative();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
